// File: rtl/wb_stage.sv
// Write-back stage: picks the write-back source, formats load data and
// waits (bounded) for a late data-memory response before writing the
// register file. Single outstanding load; the upstream stalls while one
// is pending.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | ready for an instruction; non-loads and loads whose data
//            | is already present complete in one cycle
//   WAIT_RSP | load accepted without data; waiting for dmem_rsp_valid,
//            | abandoned after LOAD_TIMEOUT cycles
module wb_stage #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_TIMEOUT = 16,
  localparam int OFS_W       = $clog2(XLEN / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_wbsel,
  input  logic [XLEN-1:0]       in_alu,
  input  logic [XLEN-1:0]       in_pc_plus_4,
  input  logic [XLEN-1:0]       in_csr,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rf_we,
  input  logic [2:0]            in_funct3,
  input  logic [OFS_W-1:0]      in_addr_lo,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rsp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  err_load,
  output logic                  err_timeout
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_RSP = 1'b1;

  localparam int CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  localparam logic [1:0] SEL_DMEM = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_CSR  = 2'b11;

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // context of a load that is waiting for its response
  logic [REG_ADDR_W-1:0] pend_rd_q;
  logic                  pend_we_q;
  logic [2:0]            pend_funct3_q;
  logic [OFS_W-1:0]      pend_addr_q;
  logic                  latch_pend;

  // load context feeding the formatter: live inputs in IDLE, latched in WAIT_RSP
  logic [REG_ADDR_W-1:0] ld_rd;
  logic                  ld_we;
  logic [2:0]            ld_funct3;
  logic [OFS_W-1:0]      ld_addr;

  logic [XLEN-1:0]       sh_b, sh_h, sh_w;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [31:0]           word_v;
  logic [XLEN-1:0]       fmt_data;
  logic                  fmt_illegal;

  logic [XLEN-1:0]       src_data;
  logic                  accept;

  logic                  done;
  logic                  done_we;
  logic [REG_ADDR_W-1:0] done_waddr;
  logic [XLEN-1:0]       done_wdata;
  logic                  set_err_load;
  logic                  set_err_to;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  // choose between live instruction fields and the pending load context
  always_comb begin
    if (state_q == WAIT_RSP) begin
      ld_rd     = pend_rd_q;
      ld_we     = pend_we_q;
      ld_funct3 = pend_funct3_q;
      ld_addr   = pend_addr_q;
    end else begin
      ld_rd     = in_rd;
      ld_we     = in_rf_we;
      ld_funct3 = in_funct3;
      ld_addr   = in_addr_lo;
    end
  end

  // the 32-bit lane only exists as a choice when the bus is 64 bits wide
  if (XLEN == 64) begin : g_word64
    assign sh_w = dmem_rsp_data >> {ld_addr[OFS_W-1], 5'b00000};
  end else begin : g_word32
    assign sh_w = dmem_rsp_data;
  end

  // extract byte/half/word lanes and extend according to the load type
  always_comb begin
    sh_b     = dmem_rsp_data >> {ld_addr, 3'b000};
    sh_h     = dmem_rsp_data >> {ld_addr[OFS_W-1:1], 4'b0000};
    byte_v   = sh_b[7:0];
    half_v   = sh_h[15:0];
    word_v   = sh_w[31:0];
    fmt_data = dmem_rsp_data;
    case (ld_funct3)
      3'b000:  fmt_data = XLEN'($signed(byte_v));
      3'b100:  fmt_data = XLEN'(byte_v);
      3'b001:  fmt_data = XLEN'($signed(half_v));
      3'b101:  fmt_data = XLEN'(half_v);
      3'b010:  fmt_data = XLEN'($signed(word_v));
      3'b110:  fmt_data = XLEN'(word_v);
      default: fmt_data = dmem_rsp_data;
    endcase
  end

  // unsupported widths for this XLEN and misaligned accesses are illegal
  always_comb begin
    fmt_illegal = 1'b0;
    case (ld_funct3)
      3'b111:        fmt_illegal = 1'b1;
      3'b110:        fmt_illegal = (XLEN == 32) || (ld_addr[1:0] != 2'b00);
      3'b011:        fmt_illegal = (XLEN == 32) || (ld_addr != '0);
      3'b001, 3'b101: fmt_illegal = ld_addr[0];
      3'b010:        fmt_illegal = (ld_addr[1:0] != 2'b00);
      default:       fmt_illegal = 1'b0;
    endcase
  end

  // non-load write-back source
  always_comb begin
    case (in_wbsel)
      SEL_ALU: src_data = in_alu;
      SEL_PC4: src_data = in_pc_plus_4;
      SEL_CSR: src_data = in_csr;
      default: src_data = in_alu;
    endcase
  end

  // next state, completion and error decisions
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    latch_pend   = 1'b0;
    done         = 1'b0;
    done_we      = 1'b0;
    done_waddr   = ld_rd;
    done_wdata   = fmt_data;
    set_err_load = 1'b0;
    set_err_to   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_wbsel != SEL_DMEM) begin
            done       = 1'b1;
            done_we    = in_rf_we & (in_rd != '0);
            done_waddr = in_rd;
            done_wdata = src_data;
          end else if (dmem_rsp_valid) begin
            done         = 1'b1;
            done_we      = ld_we & (ld_rd != '0) & ~fmt_illegal;
            set_err_load = fmt_illegal;
          end else begin
            latch_pend = 1'b1;
            cnt_d      = '0;
            state_d    = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        // a response on the final counted cycle still completes the load
        if (dmem_rsp_valid) begin
          done         = 1'b1;
          done_we      = ld_we & (ld_rd != '0) & ~fmt_illegal;
          set_err_load = fmt_illegal;
          state_d      = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          set_err_to = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, timeout counter and pending-load context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pend_rd_q     <= '0;
      pend_we_q     <= 1'b0;
      pend_funct3_q <= '0;
      pend_addr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_pend) begin
        pend_rd_q     <= in_rd;
        pend_we_q     <= in_rf_we;
        pend_funct3_q <= in_funct3;
        pend_addr_q   <= in_addr_lo;
      end
    end
  end

  // register-file write port: one-cycle strobe, address/data held between writes
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= done & done_we;
      if (done) begin
        rf_waddr <= done_waddr;
        rf_wdata <= done_wdata;
      end
    end
  end

  // sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_load    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (set_err_load) err_load <= 1'b1;
      if (set_err_to)   err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (XLEN=32, LOAD_TIMEOUT=4).
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wbsel;
  logic [31:0] in_alu, in_pc_plus_4, in_csr;
  logic [4:0]  in_rd;
  logic        in_rf_we;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err_load;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  wb_stage #(.XLEN(32), .REG_ADDR_W(5), .LOAD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wbsel(in_wbsel),
    .in_alu(in_alu), .in_pc_plus_4(in_pc_plus_4), .in_csr(in_csr),
    .in_rd(in_rd), .in_rf_we(in_rf_we), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_data(dmem_rsp_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .err_load(err_load), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid       = 1'b0;
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic issue_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                            input logic rsp, input logic [31:0] data);
    in_valid       = 1'b1;
    in_wbsel       = 2'b00;
    in_funct3      = f3;
    in_addr_lo     = lo;
    in_rd          = rd;
    in_rf_we       = 1'b1;
    dmem_rsp_valid = rsp;
    dmem_rsp_data  = data;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1; in_wbsel = 2'b01; in_alu = 32'hDEAD_0001;
    in_pc_plus_4 = 32'h0; in_csr = 32'h0; in_rd = 5'd4; in_rf_we = 1'b1;
    in_funct3 = 3'b000; in_addr_lo = 2'd0;
    dmem_rsp_valid = 1'b0; dmem_rsp_data = 32'h0;

    // reset with a valid instruction present: it must be dropped
    step(); step();
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_errl", err_load, 0);
    chk("rst_errt", err_timeout, 0);
    rst = 1'b0;
    idle_in();
    step();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_we", rf_we, 0);

    // ALU write to x5
    in_valid = 1'b1; in_wbsel = 2'b01; in_alu = 32'h0000_1234; in_rd = 5'd5; in_rf_we = 1'b1;
    step();
    idle_in();
    chk("alu_we", rf_we, 1);
    chk("alu_waddr", rf_waddr, 5);
    chk("alu_wdata", rf_wdata, 32'h0000_1234);
    step();
    chk("alu_pulse", rf_we, 0);

    // pc+4 and csr sources, back to back
    in_valid = 1'b1; in_wbsel = 2'b10; in_pc_plus_4 = 32'h0000_0104; in_rd = 5'd9;
    step();
    chk("pc4_wdata", rf_wdata, 32'h0000_0104);
    chk("pc4_waddr", rf_waddr, 9);
    in_wbsel = 2'b11; in_csr = 32'hC5C5_0001; in_rd = 5'd10;
    step();
    idle_in();
    chk("csr_we", rf_we, 1);
    chk("csr_wdata", rf_wdata, 32'hC5C5_0001);

    // delayed LB: response three cycles after accept
    issue_load(3'b000, 2'd2, 5'd7, 1'b0, 32'h0);
    step();
    idle_in();
    chk("lb_wait_ready", in_ready, 0);
    chk("lb_wait_we", rf_we, 0);
    in_valid = 1'b1; in_wbsel = 2'b01; in_rd = 5'd1;  // must be ignored while waiting
    step();
    chk("lb_wait_ready2", in_ready, 0);
    chk("lb_wait_we2", rf_we, 0);
    step();
    in_valid = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h0080_0000;
    step();
    idle_in();
    chk("lb_we", rf_we, 1);
    chk("lb_waddr", rf_waddr, 7);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_ready", in_ready, 1);
    step();
    chk("lb_pulse", rf_we, 0);

    // same-cycle loads of several types
    issue_load(3'b101, 2'd2, 5'd3, 1'b1, 32'hBEEF_0000);
    step();
    chk("lhu_wdata", rf_wdata, 32'h0000_BEEF);
    chk("lhu_we", rf_we, 1);
    chk("lhu_ready", in_ready, 1);
    issue_load(3'b001, 2'd0, 5'd4, 1'b1, 32'h1234_8001);
    step();
    chk("lh_wdata", rf_wdata, 32'hFFFF_8001);
    issue_load(3'b100, 2'd3, 5'd6, 1'b1, 32'hA500_0000);
    step();
    chk("lbu_wdata", rf_wdata, 32'h0000_00A5);
    issue_load(3'b010, 2'd0, 5'd8, 1'b1, 32'h8765_4321);
    step();
    idle_in();
    chk("lw_wdata", rf_wdata, 32'h8765_4321);
    chk("lw_waddr", rf_waddr, 8);

    // stray response while idle
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h1111_1111;
    step();
    idle_in();
    chk("stray_rsp_we", rf_we, 0);

    // response on the last counted cycle still writes
    issue_load(3'b010, 2'd0, 5'd11, 1'b0, 32'h0);
    step();
    idle_in();
    step(); step(); step();
    chk("edge_ready", in_ready, 0);
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h0BAD_CAFE;
    step();
    idle_in();
    chk("edge_we", rf_we, 1);
    chk("edge_wdata", rf_wdata, 32'h0BAD_CAFE);
    chk("edge_errt", err_timeout, 0);

    // timeout: four waiting cycles, then back to IDLE with no write
    issue_load(3'b010, 2'd0, 5'd12, 1'b0, 32'h0);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_wait_we", rf_we, 0);
    end
    chk("to_wait_ready", in_ready, 0);
    step();
    chk("to_ready", in_ready, 1);
    chk("to_errt", err_timeout, 1);
    chk("to_we", rf_we, 0);
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h2222_2222;
    step();
    idle_in();
    chk("to_late_rsp_we", rf_we, 0);

    // misaligned LW: completes without write, err_load sticks
    issue_load(3'b010, 2'd1, 5'd13, 1'b1, 32'h3333_3333);
    step();
    idle_in();
    chk("mis_we", rf_we, 0);
    chk("mis_errl", err_load, 1);
    chk("mis_ready", in_ready, 1);
    step(); step();
    chk("mis_errl_hold", err_load, 1);
    chk("mis_errt_hold", err_timeout, 1);

    // illegal LD on a 32-bit datapath
    issue_load(3'b011, 2'd0, 5'd14, 1'b1, 32'h4444_4444);
    step();
    idle_in();
    chk("ld32_we", rf_we, 0);

    // pc+4 to x0: data/address update, no strobe
    in_valid = 1'b1; in_wbsel = 2'b10; in_pc_plus_4 = 32'h0000_0208; in_rd = 5'd0; in_rf_we = 1'b1;
    step();
    idle_in();
    chk("x0_we", rf_we, 0);
    chk("x0_waddr", rf_waddr, 0);
    chk("x0_wdata", rf_wdata, 32'h0000_0208);

    // reset while waiting, then the response arrives
    issue_load(3'b010, 2'd0, 5'd15, 1'b0, 32'h0);
    step();
    idle_in();
    step();
    chk("rw_wait_ready", in_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h5555_5555;
    step();
    idle_in();
    chk("rw_we", rf_we, 0);
    chk("rw_ready", in_ready, 1);
    chk("rw_errl", err_load, 0);
    chk("rw_errt", err_timeout, 0);
    chk("rw_wdata", rf_wdata, 0);
    step();
    chk("rw_we2", rf_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
